mult_sequencer: RTL and testbench

- Iterative shift-add multiplier controller that executes the MULT instruction of the multicycle CPU and holds the 64-bit product in HI/LO for MFLO.
- Started by the main control FSM when it is in its MULT state. Reports busy so the FSM stalls until the product is ready.
- One partial-product step per clock; the datapath is owned and sequenced entirely by this block.

---
 rtl/mult_if.sv | 21 ++
 rtl/mult_sequencer.sv | 128 ++++++++++++
 tb/tb_mult_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mult_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_if
// Brief    : Request/result bundle between the control FSM and mult_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, a, b, input busy, done, hi, lo);
    modport slave  (input start, a, b, output busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mult_sequencer
// Brief    : Iterative shift-add MULT unit, one partial product per clock,
//            product held in HI/LO. MULT_SIGNED_EN selects signed operation.
// Revision : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    mult_if.slave bus
);
    localparam int                 c_cnt_w   = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_load;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [2*WIDTH-1:0] w_final;

    always_comb begin
        w_load       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = c_run;
                end
            end
            c_run: begin
                if (r_count == c_last) begin
                    w_state_next = c_done;
                end
            end
            c_done: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = c_run;
                end else begin
                    w_state_next = c_idle;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    // Carry out of the upper half becomes the top bit after the shift.
    always_comb begin
        w_addend    = r_prod[0] ? r_mcand : '0;
        w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
    end

`ifdef MULT_SIGNED_EN
    logic r_neg;

    // Magnitudes go through the unsigned datapath; 2^(WIDTH-1) survives as unsigned.
    always_comb begin
        w_op_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
        w_op_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
        w_final = r_neg ? -w_prod_next : w_prod_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    always_comb begin
        w_op_a  = bus.a;
        w_op_b  = bus.b;
        w_final = w_prod_next;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
            r_count <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_mcand <= w_op_a;
                r_prod  <= {{WIDTH{1'b0}}, w_op_b};
                r_count <= '0;
            end else if (r_state == c_run) begin
                r_prod  <= w_prod_next;
                r_count <= r_count + c_cnt_one;
                if (r_count == c_last) begin
                    r_hi <= w_final[2*WIDTH-1:WIDTH];
                    r_lo <= w_final[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.busy = (r_state == c_run);
    assign bus.done = (r_state == c_done);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_sequencer
// Brief    : Scoreboard bench for mult_sequencer (plain or MULT_SIGNED_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mult_if #(.WIDTH(WIDTH)) bus ();

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef MULT_SIGNED_EN
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
`else
        return {32'b0, x} * {32'b0, y};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit keep_start);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        sb_q.push_back(model(x, y));
        tick();
        if (!keep_start) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [63:0] entry;
        int          busy_n;
        int          cyc;
        bit          moved;
        entry  = {bus.hi, bus.lo};
        busy_n = 0;
        cyc    = 0;
        moved  = 1'b0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) busy_n++;
            if ({bus.hi, bus.lo} !== entry) moved = 1'b1;
            cyc++;
            tick();
        end
        check_eq({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
        check_eq({tag, "_hilo_held"}, 64'(moved), 64'd0);
        check_eq({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check_eq({tag, "_product"}, {bus.hi, bus.lo}, sb_q.pop_front());
    endtask

    task automatic idle_after(input string tag);
        tick();
        check_eq({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    endtask

    logic [31:0] va[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h8000_0000,
                           32'h0000_0000, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [31:0] vb[6] = '{32'h0000_0005, 32'hFFFF_FFFC, 32'h0000_0002,
                           32'hDEAD_BEEF, 32'h9ABC_DEF0, 32'h8000_0001};

    initial begin
        int done_cnt;
        bus.start = 1'b1;
        bus.a     = 32'h1;
        bus.b     = 32'h1;

        // Reset held with start asserted
        tick();
        tick();
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset     = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        check_eq("idle_done", 64'(bus.done), 64'd0);

        launch(32'd3, 32'd5, 1'b0);
        wait_done("basic");
        idle_after("basic");

        // Operands change while the run is in flight
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        bus.a = 32'h0000_0001;
        bus.b = 32'h0000_0002;
        wait_done("carry");
        idle_after("carry");

        // Start held through RUN, then back-to-back restart in DONE
        launch(32'd7, 32'd6, 1'b1);
        wait_done("held");
        bus.a = 32'd2;
        bus.b = 32'd9;
        sb_q.push_back(model(32'd2, 32'd9));
        tick();
        bus.start = 1'b0;
        check_eq("b2b_no_idle", 64'(bus.busy), 64'd1);
        check_eq("b2b_old_hilo", {bus.hi, bus.lo}, model(32'd7, 32'd6));
        wait_done("b2b");
        idle_after("b2b");

        // Asynchronous reset in the middle of a run
        launch(32'd100, 32'd100, 1'b0);
        void'(sb_q.pop_back());
        repeat (9) tick();
        #2 reset = 1'b0;
        #1;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        tick();
        reset    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        check_eq("abort_no_done", 64'(done_cnt), 64'd0);
        launch(32'd4, 32'd4, 1'b0);
        wait_done("after_abort");
        idle_after("after_abort");

        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i], 1'b0);
            wait_done($sformatf("vec%0d", i));
            idle_after($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            launch($urandom, $urandom, 1'b0);
            wait_done($sformatf("rand%0d", i));
            idle_after($sformatf("rand%0d", i));
        end

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
